viterbi_dec_ctrl: RTL and testbench
===================================

Name: viterbi_dec_ctrl

Overview:
Frame sequencer for the rate-1/2 Viterbi decoder. It accepts received code pairs over a valid/ready handshake and presents each one to the branch-metric units. It strobes the add-compare-select (ACS) bank, generates trellis-memory write and read addresses, and runs traceback. It reorders the traceback bits, which arrive last-first, into forward order and emits them to the downstream consumer.

Parameters:
FRAME_LEN, 16, number of code pairs (and decoded bits) per frame; must be a power of 2 and at least 4
AW, $clog2(FRAME_LEN), trellis address width; localparam, not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
start_in  in  1  begin a frame; sampled in IDLE only
rx_valid_in  in  1  rx_pair_in valid
rx_pair_in  in  2  received code pair
rx_ready_out  out  1  controller accepts a pair this cycle
bmc_pair_out  out  2  registered pair driving the branch-metric units
acs_en_out  out  1  ACS/path-metric update strobe
acs_init_out  out  1  first trellis step: path metrics start from state 0
trellis_we_out  out  1  survivor-memory write enable
trellis_waddr_out  out  AW  survivor-memory write address (trellis step)
tb_en_out  out  1  traceback step enable
trellis_raddr_out  out  AW  survivor-memory read address
tb_bit_in  in  1  decoded bit, valid one cycle after tb_en_out
dec_valid_out  out  1  decoded bit valid
dec_bit_out  out  1  decoded bit
dec_last_out  out  1  final bit of frame
dec_ready_in  in  1  consumer accepts bit
busy_out  out  1  high in any state other than IDLE
done_out  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, rst=1):
  - state returns to IDLE; all outputs are 0; step counter and reorder buffer are cleared.
  - Any in-flight frame is discarded. Reset applies immediately, mid-frame included.
- States are IDLE, ACS, BEST, TRACE, DRAIN and EMIT.
- IDLE:
  - rx_ready_out=0.
  - start_in=1 moves to ACS next cycle with step k=0.
  - rx_valid_in is ignored.
- ACS:
  - rx_ready_out=1.
  - A handshake in cycle t produces, in cycle t+1: bmc_pair_out=pair, acs_en_out=1, trellis_we_out=1, trellis_waddr_out=k, and acs_init_out=1 only when k=0. Then k increments.
  - These strobes are single-cycle pulses. bmc_pair_out holds its value between pulses.
  - Gaps in rx_valid_in stall without penalty.
  - The handshake with k=FRAME_LEN-1 moves the state to BEST. rx_ready_out is 0 from the following cycle.
- BEST:
  - Lasts 1 cycle and carries the final ACS pulse. It gives the external best-metric selector time to settle.
  - Then moves to TRACE.
- TRACE:
  - Lasts FRAME_LEN cycles. tb_en_out=1 and trellis_raddr_out counts FRAME_LEN-1 down to 0.
  - tb_bit_in sampled in the cycle after address r is stored in buf[r].
- DRAIN:
  - Lasts 1 cycle and captures the bit for r=0.
  - Then moves to EMIT with index i=0.
- EMIT:
  - dec_valid_out=1 and dec_bit_out=buf[i].
  - dec_last_out=1 when i=FRAME_LEN-1.
  - i advances only when dec_ready_in=1. Outputs hold stable while dec_ready_in=0.
  - On the handshake of the last bit: next cycle is IDLE with done_out=1 for exactly one cycle.
- busy_out=1 in all states except IDLE.
- start_in outside IDLE is ignored.
- start_in asserted in the same cycle done_out pulses is ignored. The controller is already back in IDLE, so start_in in the following cycle starts a new frame.
- Counters are AW bits wide. Wrap from FRAME_LEN-1 never occurs in normal operation because the state transition occurs at that count.
- Minimum frame latency:
  - from the first rx handshake to the first dec_valid_out = FRAME_LEN+FRAME_LEN+2 cycles, with a continuous stream;
  - from start_in to done_out = 3*FRAME_LEN+4 cycles, with a continuous stream and dec_ready_in=1.

Decomposition:
- Package viterbi_pkg contains:
  - the state enum (IDLE, ACS, BEST, TRACE, DRAIN, EMIT);
  - the constant DEFAULT_FRAME_LEN=16;
  - a code-pair typedef (logic[1:0]).
- One sub-module, tb_reorder_buf, holds the FRAME_LEN-bit buffer:
  - write port: addressed write (we, waddr, wbit);
  - read port: combinational read at raddr;
  - cleared on rst.

Test Plan:
- Reset mid-ACS: drive rst at k=7 with rx_valid_in held high. Required: all outputs 0 at once and state IDLE. A later start_in processes a full 16-pair frame, with trellis_waddr_out starting at 0.
- Continuous frame:
  - Stimulus: FRAME_LEN=16, start_in then 16 back-to-back pairs (3,0,1,2 repeating), dec_ready_in=1.
  - Required: 16 ACS pulses with waddr 0..15, acs_init_out only on the first, bmc_pair_out matching each pair.
  - Required: TRACE raddr 15..0.
  - Required: done_out exactly 3*16+4=52 cycles after start_in.
- Reorder: tb_bit_in returns bit (r mod 3 == 0) for each address r. Required: dec_bit_out sequence 1,0,0,1,0,0,... for i=0..15, with dec_last_out only on i=15.
- Rx stall: rx_valid_in low for 3 cycles after every other pair. Required: no ACS pulse during gaps, addresses still contiguous 0..15, no pair dropped or duplicated.
- Output backpressure: dec_ready_in low for 5 cycles at i=4. Required: dec_bit_out and dec_valid_out hold buf[4], then resume; done_out delayed by exactly 5 cycles.
- Illegal start: start_in pulsed during TRACE, and also in the done_out cycle. Required: no state change and busy_out continuous. A start_in one cycle later begins a new frame.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi decoder frame controller.
//   state_t           : controller state encoding
//   DEFAULT_FRAME_LEN : default number of code pairs per frame
//   code_pair_t       : one received rate-1/2 code pair
package viterbi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACS   = 3'd1,
        BEST  = 3'd2,
        TRACE = 3'd3,
        DRAIN = 3'd4,
        EMIT  = 3'd5
    } state_t;

    localparam int DEFAULT_FRAME_LEN = 16;

    typedef logic [1:0] code_pair_t;

endpackage

// File: rtl/tb_reorder_buf.sv
// Traceback reorder buffer: N single-bit entries.
//   clk, rst : clock, asynchronous active-high clear
//   we/waddr/wbit : addressed write of one traceback bit
//   raddr/rbit    : combinational read
module tb_reorder_buf #(
    parameter  int N  = 16,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wbit,
    input  logic [AW-1:0] raddr,
    output logic          rbit
);

    logic [N-1:0] bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits <= '0;
        end else if (we) begin
            bits[waddr] <= wbit;
        end
    end

    assign rbit = bits[raddr];

endmodule

// File: rtl/viterbi_dec_ctrl.sv
// Frame sequencer for the rate-1/2 Viterbi decoder.
//   start_in                      : begin a frame (IDLE only, not in the done cycle)
//   rx_valid_in/rx_pair_in/rx_ready_out : received code pair handshake
//   bmc_pair_out, acs_en_out, acs_init_out : branch-metric / ACS strobes
//   trellis_we_out/trellis_waddr_out       : survivor-memory write
//   tb_en_out/trellis_raddr_out/tb_bit_in  : traceback read, bit returns a cycle later
//   dec_valid_out/dec_bit_out/dec_last_out/dec_ready_in : forward-order output
//   busy_out, done_out            : status
// Handshakes: a transfer happens in any cycle where valid and ready are both
// high at the rising edge; valid/data are held by the source until accepted.
module viterbi_dec_ctrl
    import viterbi_pkg::*;
#(
    parameter  int FRAME_LEN = DEFAULT_FRAME_LEN,
    localparam int AW        = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_in,
    input  logic          rx_valid_in,
    input  code_pair_t    rx_pair_in,
    output logic          rx_ready_out,
    output code_pair_t    bmc_pair_out,
    output logic          acs_en_out,
    output logic          acs_init_out,
    output logic          trellis_we_out,
    output logic [AW-1:0] trellis_waddr_out,
    output logic          tb_en_out,
    output logic [AW-1:0] trellis_raddr_out,
    input  logic          tb_bit_in,
    output logic          dec_valid_out,
    output logic          dec_bit_out,
    output logic          dec_last_out,
    input  logic          dec_ready_in,
    output logic          busy_out,
    output logic          done_out
);

    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;          // ACS step k, traceback address r, emit index i
    logic          ready_q;
    logic          acs_en_q, acs_init_q, we_q, done_q;
    logic [AW-1:0] waddr_q;
    code_pair_t    bmc_q;
    logic          tb_pend;      // a traceback bit returns this cycle
    logic [AW-1:0] tb_addr_q;    // address that bit belongs to
    logic          buf_bit;
    logic          start_ok, rx_hs, last_rx, emit_hs;

    // A start coinciding with the done pulse belongs to the finished frame.
    assign start_ok = (state == IDLE) && start_in && !done_q;
    assign rx_hs    = (state == ACS) && ready_q && rx_valid_in;
    assign last_rx  = rx_hs && (cnt == LAST);
    assign emit_hs  = (state == EMIT) && dec_ready_in;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ACS;
            ACS:     if (last_rx) state_nxt = BEST;
            BEST:    state_nxt = TRACE;
            TRACE:   if (cnt == '0) state_nxt = DRAIN;
            DRAIN:   state_nxt = EMIT;
            EMIT:    if (emit_hs && (cnt == LAST)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Step counter. It stops at LAST on the final pair so traceback starts
    // from the top address, and stops at 0 after traceback so emit starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE:  if (start_ok) cnt <= '0;
                ACS:   if (rx_hs && (cnt != LAST)) cnt <= cnt + 1'b1;
                TRACE: if (cnt != '0) cnt <= cnt - 1'b1;
                EMIT:  if (emit_hs) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Registered strobes. rx ready is registered, so the first ACS cycle
    // is a setup cycle with ready low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q    <= 1'b0;
            acs_en_q   <= 1'b0;
            acs_init_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            bmc_q      <= '0;
            done_q     <= 1'b0;
            tb_pend    <= 1'b0;
            tb_addr_q  <= '0;
        end else begin
            ready_q    <= (state == ACS) && !last_rx;
            acs_en_q   <= rx_hs;
            we_q       <= rx_hs;
            acs_init_q <= rx_hs && (cnt == '0);
            if (rx_hs) begin
                waddr_q <= cnt;
                bmc_q   <= rx_pair_in;
            end
            done_q    <= emit_hs && (cnt == LAST);
            tb_pend   <= (state == TRACE);
            tb_addr_q <= cnt;
        end
    end

    tb_reorder_buf #(.N(FRAME_LEN)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (tb_pend),
        .waddr (tb_addr_q),
        .wbit  (tb_bit_in),
        .raddr (cnt),
        .rbit  (buf_bit)
    );

    // Output logic
    always_comb begin
        rx_ready_out      = ready_q;
        bmc_pair_out      = bmc_q;
        acs_en_out        = acs_en_q;
        acs_init_out      = acs_init_q;
        trellis_we_out    = we_q;
        trellis_waddr_out = waddr_q;
        tb_en_out         = (state == TRACE);
        trellis_raddr_out = (state == TRACE) ? cnt : '0;
        dec_valid_out     = (state == EMIT);
        dec_bit_out       = (state == EMIT) && buf_bit;
        dec_last_out      = (state == EMIT) && (cnt == LAST);
        busy_out          = (state != IDLE);
        done_out          = done_q;
    end

endmodule

// File: tb/tb_viterbi_dec_ctrl.sv
// Directed bench for viterbi_dec_ctrl with FRAME_LEN=16.
module tb_viterbi_dec_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_in = 1'b0;
  logic       rx_valid_in = 1'b0;
  logic [1:0] rx_pair_in = 2'b00;
  logic       rx_ready_out;
  logic [1:0] bmc_pair_out;
  logic       acs_en_out, acs_init_out, trellis_we_out;
  logic [3:0] trellis_waddr_out, trellis_raddr_out;
  logic       tb_en_out;
  logic       tb_bit_in = 1'b0;
  logic       dec_valid_out, dec_bit_out, dec_last_out;
  logic       dec_ready_in = 1'b1;
  logic       busy_out, done_out;

  viterbi_dec_ctrl #(.FRAME_LEN(16)) dut (
    .clk(clk), .rst(rst), .start_in(start_in),
    .rx_valid_in(rx_valid_in), .rx_pair_in(rx_pair_in), .rx_ready_out(rx_ready_out),
    .bmc_pair_out(bmc_pair_out), .acs_en_out(acs_en_out), .acs_init_out(acs_init_out),
    .trellis_we_out(trellis_we_out), .trellis_waddr_out(trellis_waddr_out),
    .tb_en_out(tb_en_out), .trellis_raddr_out(trellis_raddr_out), .tb_bit_in(tb_bit_in),
    .dec_valid_out(dec_valid_out), .dec_bit_out(dec_bit_out), .dec_last_out(dec_last_out),
    .dec_ready_in(dec_ready_in), .busy_out(busy_out), .done_out(done_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] pair_of(input int pat, input int k);
    if (pat == 0) begin
      case (k % 4)
        0: return 2'd3;
        1: return 2'd0;
        2: return 2'd1;
        default: return 2'd2;
      endcase
    end
    return 2'(k % 4) ^ 2'((k / 4) % 4);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [1:0] exp_q[$];
  logic [1:0] ep;
  logic [1:0] last_pair = 2'b00;
  bit         mon_on = 1'b0;
  bit         hs_prev = 1'b0;
  int         acs_idx, trace_exp, trace_cnt, emit_idx, done_cnt, hold_err, stray_err;
  bit         pend = 1'b0;
  logic [3:0] pend_r = 4'd0;

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check("acs_en_align", 32'(acs_en_out), 32'(hs_prev));
      if (trellis_we_out !== acs_en_out) stray_err++;
      if (acs_en_out) begin
        if (exp_q.size() == 0) stray_err++;
        else begin
          ep = exp_q.pop_front();
          check("bmc_pair", 32'(bmc_pair_out), 32'(ep));
          last_pair = ep;
        end
        check("waddr", 32'(trellis_waddr_out), 32'(acs_idx));
        check("acs_init", 32'(acs_init_out), 32'(acs_idx == 0));
        acs_idx++;
      end else begin
        if (acs_init_out !== 1'b0) stray_err++;
        if (bmc_pair_out !== last_pair) hold_err++;
      end
      hs_prev = rx_valid_in && rx_ready_out;
      if (tb_en_out) begin
        check("raddr", 32'(trellis_raddr_out), 32'(trace_exp));
        trace_exp--;
        trace_cnt++;
      end
      if (dec_valid_out) begin
        check("dec_bit", 32'(dec_bit_out), 32'((emit_idx % 3) == 0));
        check("dec_last", 32'(dec_last_out), 32'(emit_idx == 15));
        if (dec_ready_in) emit_idx++;
      end
      if (done_out) done_cnt++;
    end else begin
      hs_prev = 1'b0;
    end
    pend   = tb_en_out;
    pend_r = trellis_raddr_out;
  end

  // Survivor-memory model: bit for address r is (r mod 3 == 0), one cycle late.
  always @(posedge clk) begin
    #1;
    tb_bit_in = pend ? ((pend_r % 3) == 0) : 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_init(input int pat);
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(pair_of(pat, k));
    acs_idx = 0; trace_exp = 15; trace_cnt = 0; emit_idx = 0;
    done_cnt = 0; hold_err = 0; stray_err = 0;
    mon_on = 1'b1;
  endtask

  // One frame: pattern, rx gaps, backpressure index (-1 none), start during
  // TRACE, start in the done cycle, expected start-to-done latency (-1 skip).
  task automatic run_frame(input int pat, input bit gap, input int bp_idx,
                           input bit trace_start, input bit done_start, input int exp_lat);
    int s, k, to, gap_left, bp_left, busy_gap;
    bit seen_done, ts, tb_seen;
    mon_init(pat);
    busy_gap = 0; gap_left = 0; bp_left = 5; seen_done = 0; ts = 0; tb_seen = 0;
    tick();
    start_in = 1'b1;
    s = cyc;
    @(negedge clk);
    check("idle_at_start", 32'(busy_out), 32'd0);
    k = 0; to = 0;
    while (k < 16 && to < 200) begin
      tick();
      start_in = 1'b0;
      if (gap_left > 0) begin
        rx_valid_in = 1'b0; rx_pair_in = 2'b11; gap_left--;
      end else begin
        rx_valid_in = 1'b1; rx_pair_in = pair_of(pat, k);
      end
      @(negedge clk);
      to++;
      if (busy_out !== 1'b1) busy_gap++;
      if (rx_valid_in && rx_ready_out) begin
        if (gap && (k % 2 == 1)) gap_left = 3;
        k++;
      end
    end
    check("rx_pairs_taken", 32'(k), 32'd16);
    to = 0;
    while (!seen_done && to < 300) begin
      tick();
      rx_valid_in = 1'b0; start_in = 1'b0; dec_ready_in = 1'b1;
      if (trace_start && !ts && tb_seen) begin start_in = 1'b1; ts = 1; end
      if (bp_idx >= 0 && dec_valid_out && emit_idx == bp_idx && bp_left > 0) begin
        dec_ready_in = 1'b0; bp_left--;
      end
      if (done_start && cyc == s + exp_lat) start_in = 1'b1;
      @(negedge clk);
      to++;
      if (!dec_ready_in) check("bp_valid_hold", 32'(dec_valid_out), 32'd1);
      if (tb_en_out) tb_seen = 1;
      if (done_out) begin
        seen_done = 1;
        if (exp_lat > 0) check("done_latency", 32'(cyc - s), 32'(exp_lat));
      end else if (busy_out !== 1'b1) busy_gap++;
    end
    #1;
    check("done_seen", 32'(seen_done), 32'd1);
    check("acs_count", 32'(acs_idx), 32'd16);
    check("trace_count", 32'(trace_cnt), 32'd16);
    check("emit_count", 32'(emit_idx), 32'd16);
    check("done_count", 32'(done_cnt), 32'd1);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("bmc_hold", 32'(hold_err), 32'd0);
    check("stray_strobe", 32'(stray_err), 32'd0);
    check("busy_continuous", 32'(busy_gap), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready_out), 32'd0);
    check({tag, "_bmc"}, 32'(bmc_pair_out), 32'd0);
    check({tag, "_acs_en"}, 32'(acs_en_out), 32'd0);
    check({tag, "_acs_init"}, 32'(acs_init_out), 32'd0);
    check({tag, "_we"}, 32'(trellis_we_out), 32'd0);
    check({tag, "_waddr"}, 32'(trellis_waddr_out), 32'd0);
    check({tag, "_tb_en"}, 32'(tb_en_out), 32'd0);
    check({tag, "_raddr"}, 32'(trellis_raddr_out), 32'd0);
    check({tag, "_dec_valid"}, 32'(dec_valid_out), 32'd0);
    check({tag, "_dec_bit"}, 32'(dec_bit_out), 32'd0);
    check({tag, "_dec_last"}, 32'(dec_last_out), 32'd0);
    check({tag, "_busy"}, 32'(busy_out), 32'd0);
    check({tag, "_done"}, 32'(done_out), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, to;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_all_zero("idle");

    // Reset in the middle of ACS with rx_valid held high.
    mon_init(0);
    tick();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    k = 0; to = 0;
    while (k < 7 && to < 50) begin
      rx_valid_in = 1'b1; rx_pair_in = pair_of(0, k);
      @(negedge clk);
      to++;
      if (rx_ready_out) k++;
      tick();
    end
    check("pre_reset_pairs", 32'(k), 32'd7);
    check("pre_reset_acs", 32'(acs_en_out), 32'd1);
    rx_valid_in = 1'b1; rx_pair_in = pair_of(0, 7);
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    last_pair = 2'b00;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("post_rst_busy", 32'(busy_out), 32'd0);
    check("post_rst_ready", 32'(rx_ready_out), 32'd0);
    rx_valid_in = 1'b0;

    // Full frames.
    run_frame(0, 1'b0, -1, 1'b0, 1'b0, 52);   // continuous, 3,0,1,2 pattern
    run_frame(1, 1'b1, -1, 1'b0, 1'b0, 73);   // rx gaps of 3 after every other pair
    run_frame(0, 1'b0, 4, 1'b0, 1'b0, 57);    // 5-cycle backpressure at i=4
    run_frame(1, 1'b0, -1, 1'b1, 1'b1, 52);   // start in TRACE and in done cycle
    run_frame(0, 1'b0, -1, 1'b0, 1'b0, 52);   // begins one cycle after that done

    start_in = 1'b0;
    mon_on = 1'b0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
